// File: rtl/bcd_interval_timer.sv
// Packed-BCD interval timer: countdown or stopwatch, prescaled LSD steps, pause, auto-reload, done pulse.
// Optional lap capture register is built only when BCD_TIMER_LAP_EN is defined.
module bcd_interval_timer #(
    parameter int DIGITS      = 5,
    parameter int TICK_CYCLES = 50000,
    parameter int TICK_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DIGITS*4-1:0]   StartValue,
    input  logic                  Mode,
    input  logic                  Restart,
    input  logic                  Run,
    input  logic                  AutoReload,
    input  logic                  Lap,
    output logic [DIGITS*4-1:0]   CurrentValue,
    output logic [DIGITS*4-1:0]   LapValue,
    output logic                  TimerDone,
    output logic                  DonePulse,
    output logic                  Tick
);

    localparam int VAL_W = DIGITS * 4;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [VAL_W-1:0]   count_q, count_d;
    logic [VAL_W-1:0]   target_q, target_d;
    logic               mode_q, mode_d;
    logic [VAL_W-1:0]   disp_d;
    logic               pulse_d;
    logic               show_term;

    logic [VAL_W-1:0]   start_clamped;
    logic [VAL_W-1:0]   idle_load;
    logic [VAL_W-1:0]   reload_val;
    logic [VAL_W-1:0]   stepped;
    logic               at_terminal;

    function automatic logic [VAL_W-1:0] bcd_clamp(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // One LSD step with ripple carry (up) or borrow (down) through every digit.
    function automatic logic [VAL_W-1:0] bcd_step(input logic [VAL_W-1:0] v, input logic up);
        logic [VAL_W-1:0] r;
        logic             ripple;
        r      = v;
        ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                if (up) begin
                    if (v[i*4 +: 4] >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        ripple      = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        ripple      = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign start_clamped = bcd_clamp(StartValue);
    assign idle_load     = Mode ? '0 : start_clamped;
    assign reload_val    = mode_q ? '0 : target_q;
    assign stepped       = bcd_step(count_q, mode_q);
    assign at_terminal   = mode_q ? (stepped == target_q) : (stepped == '0);

    // PAUSE keeps stepping logic alive so the resume edge itself counts as a run cycle.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        target_d  = target_q;
        mode_d    = mode_q;
        pulse_d   = 1'b0;
        show_term = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d  = '0;
                mode_d   = Mode;
                target_d = start_clamped;
                count_d  = idle_load;
                if (Run) begin
                    if (!Mode && (start_clamped == '0)) begin
                        state_d = DONE;
                        pulse_d = !Restart;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN, PAUSE: begin
                if (Run) begin
                    state_d = RUN;
                    if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        count_d = stepped;
                        if (at_terminal) begin
                            pulse_d = 1'b1;
                            // A zero stopwatch target free-runs and never parks in DONE.
                            if (AutoReload || (mode_q && (target_q == '0))) begin
                                count_d   = reload_val;
                                show_term = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + TICK_W'(1);
                    end
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
            end
        endcase

        if (Restart) begin
            state_d   = IDLE;
            presc_d   = '0;
            count_d   = idle_load;
            show_term = 1'b0;
        end

        // On a reload the terminal value stays visible for the pulse cycle.
        disp_d = show_term ? stepped : count_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            count_q      <= '0;
            target_q     <= '0;
            mode_q       <= 1'b0;
            CurrentValue <= '0;
            TimerDone    <= 1'b0;
            DonePulse    <= 1'b0;
            Tick         <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            target_q     <= target_d;
            mode_q       <= mode_d;
            CurrentValue <= disp_d;
            TimerDone    <= (state_d == DONE);
            DonePulse    <= pulse_d;
            Tick         <= (state_d == RUN) && (presc_d == TICK_LAST);
        end
    end

`ifdef BCD_TIMER_LAP_EN
    // Captures the displayed value, so a lap on a step edge records the pre-step value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            LapValue <= '0;
        end else if (state_q == IDLE) begin
            LapValue <= '0;
        end else if (Lap && ((state_q == RUN) || (state_q == PAUSE))) begin
            LapValue <= CurrentValue;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = Lap;
    assign LapValue   = '0;
`endif

endmodule

// File: tb/tb_bcd_interval_timer.sv
// Directed self-checking bench for bcd_interval_timer with DIGITS=3, TICK_CYCLES=4.
// Expected values are hand-derived edge counts; edge 0 is the edge that samples Run high in IDLE.
module tb_bcd_interval_timer;

    logic        CLK;
    logic        RST;
    logic [11:0] StartValue;
    logic        Mode;
    logic        Restart;
    logic        Run;
    logic        AutoReload;
    logic        Lap;
    logic [11:0] CurrentValue;
    logic [11:0] LapValue;
    logic        TimerDone;
    logic        DonePulse;
    logic        Tick;

    int compared;
    int mismatched;
    int pulseCount;

    bcd_interval_timer #(
        .DIGITS     (3),
        .TICK_CYCLES(4),
        .TICK_W     (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .StartValue  (StartValue),
        .Mode        (Mode),
        .Restart     (Restart),
        .Run         (Run),
        .AutoReload  (AutoReload),
        .Lap         (Lap),
        .CurrentValue(CurrentValue),
        .LapValue    (LapValue),
        .TimerDone   (TimerDone),
        .DonePulse   (DonePulse),
        .Tick        (Tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic restart, input logic mode,
                                 input logic [11:0] start, input logic autoReload);
        Run        = run;
        Restart    = restart;
        Mode       = mode;
        StartValue = start;
        AutoReload = autoReload;
    endtask

    // Leaves the bench 1 ns after the n-th rising edge.
    task automatic tickClocks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        pulseCount = 0;
        Lap        = 1'b0;
        RST        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h012, 1'b0);

        #12;
        checkOutput("reset_value", 32'(CurrentValue), 32'h0);
        checkOutput("reset_done", 32'(TimerDone), 32'h0);
        checkOutput("reset_pulse", 32'(DonePulse), 32'h0);
        checkOutput("reset_tick", 32'(Tick), 32'h0);
        #10;
        RST = 1'b1;

        tickClocks(1);
        checkOutput("idle_load", 32'(CurrentValue), 32'h012);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0A5, 1'b0);
        tickClocks(1);
        checkOutput("idle_clamp", 32'(CurrentValue), 32'h095);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h012, 1'b0);
        tickClocks(1);

        // Plain countdown from 012 with Run held high: terminal at edge 48.
        Run = 1'b1;
        tickClocks(1);
        checkOutput("cd_e0_value", 32'(CurrentValue), 32'h012);
        tickClocks(3);
        checkOutput("cd_e3_tick", 32'(Tick), 32'h1);
        checkOutput("cd_e3_value", 32'(CurrentValue), 32'h012);
        tickClocks(1);
        checkOutput("cd_e4_value", 32'(CurrentValue), 32'h011);
        checkOutput("cd_e4_tick", 32'(Tick), 32'h0);
        tickClocks(8);
        checkOutput("cd_e12_borrow", 32'(CurrentValue), 32'h009);
        tickClocks(35);
        checkOutput("cd_e47_value", 32'(CurrentValue), 32'h001);
        checkOutput("cd_e47_pulse", 32'(DonePulse), 32'h0);
        tickClocks(1);
        checkOutput("cd_e48_value", 32'(CurrentValue), 32'h000);
        checkOutput("cd_e48_pulse", 32'(DonePulse), 32'h1);
        checkOutput("cd_e48_done", 32'(TimerDone), 32'h1);
        tickClocks(1);
        checkOutput("cd_e49_pulse", 32'(DonePulse), 32'h0);
        checkOutput("cd_e49_done", 32'(TimerDone), 32'h1);
        checkOutput("cd_e49_hold", 32'(CurrentValue), 32'h000);

        applyStimulus(1'b0, 1'b1, 1'b0, 12'h012, 1'b0);
        tickClocks(1);
        checkOutput("rst_done_value", 32'(CurrentValue), 32'h012);
        checkOutput("rst_done_level", 32'(TimerDone), 32'h0);
        Restart = 1'b0;
        tickClocks(1);

        // Run low for 7 sampled edges (10..16): terminal slips from edge 48 to 55.
        Run = 1'b1;
        tickClocks(1);
        tickClocks(9);
        checkOutput("pause_e9_value", 32'(CurrentValue), 32'h010);
        Run = 1'b0;
        tickClocks(7);
        checkOutput("pause_e16_hold", 32'(CurrentValue), 32'h010);
        Run = 1'b1;
        tickClocks(38);
        checkOutput("pause_e54_value", 32'(CurrentValue), 32'h001);
        checkOutput("pause_e54_pulse", 32'(DonePulse), 32'h0);
        tickClocks(1);
        checkOutput("pause_e55_value", 32'(CurrentValue), 32'h000);
        checkOutput("pause_e55_pulse", 32'(DonePulse), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        tickClocks(1);
        Restart = 1'b0;
        tickClocks(1);

        // Countdown from zero goes straight to DONE.
        Run = 1'b1;
        tickClocks(1);
        checkOutput("zero_pulse", 32'(DonePulse), 32'h1);
        checkOutput("zero_done", 32'(TimerDone), 32'h1);
        checkOutput("zero_value", 32'(CurrentValue), 32'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h012, 1'b0);
        tickClocks(1);
        checkOutput("zero_restart", 32'(TimerDone), 32'h0);
        Restart = 1'b0;
        tickClocks(1);

        // Lap at 007 (edges 20..23), then async reset mid-cycle.
        Run = 1'b1;
        tickClocks(1);
        tickClocks(21);
        Lap = 1'b1;
        tickClocks(1);
        Lap = 1'b0;
        checkOutput("lap_e22_value", 32'(CurrentValue), 32'h007);
`ifdef BCD_TIMER_LAP_EN
        checkOutput("lap_e22_capture", 32'(LapValue), 32'h007);
`else
        checkOutput("lap_e22_capture", 32'(LapValue), 32'h000);
`endif
        tickClocks(2);
        checkOutput("lap_e24_value", 32'(CurrentValue), 32'h006);
`ifdef BCD_TIMER_LAP_EN
        checkOutput("lap_e24_hold", 32'(LapValue), 32'h007);
`else
        checkOutput("lap_e24_hold", 32'(LapValue), 32'h000);
`endif
        tickClocks(2);
        #3;
        RST = 1'b0;
        #1;
        checkOutput("async_value", 32'(CurrentValue), 32'h000);
        checkOutput("async_lap", 32'(LapValue), 32'h000);
        checkOutput("async_done", 32'(TimerDone), 32'h0);
        checkOutput("async_pulse", 32'(DonePulse), 32'h0);
        Run = 1'b0;
        tickClocks(1);
        RST = 1'b1;
        tickClocks(1);

        // Stopwatch to 015 with auto-reload: pulses at edges 60 and 120.
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h015, 1'b1);
        tickClocks(1);
        checkOutput("up_idle_zero", 32'(CurrentValue), 32'h000);
        Run = 1'b1;
        tickClocks(1);
        tickClocks(40);
        checkOutput("up_e40_carry", 32'(CurrentValue), 32'h010);
        tickClocks(20);
        checkOutput("up_e60_value", 32'(CurrentValue), 32'h015);
        checkOutput("up_e60_pulse", 32'(DonePulse), 32'h1);
        tickClocks(1);
        checkOutput("up_e61_value", 32'(CurrentValue), 32'h000);
        checkOutput("up_e61_pulse", 32'(DonePulse), 32'h0);
        checkOutput("up_e61_done", 32'(TimerDone), 32'h0);
        tickClocks(3);
        checkOutput("up_e64_value", 32'(CurrentValue), 32'h001);
        tickClocks(55);
        checkOutput("up_e119_value", 32'(CurrentValue), 32'h014);
        checkOutput("up_e119_pulse", 32'(DonePulse), 32'h0);
        tickClocks(1);
        checkOutput("up_e120_value", 32'(CurrentValue), 32'h015);
        checkOutput("up_e120_pulse", 32'(DonePulse), 32'h1);

        // Restart coinciding with the terminal step at edge 180.
        tickClocks(59);
        Restart = 1'b1;
        tickClocks(1);
        checkOutput("rst_term_pulse", 32'(DonePulse), 32'h1);
        checkOutput("rst_term_done", 32'(TimerDone), 32'h0);
        checkOutput("rst_term_value", 32'(CurrentValue), 32'h000);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h012, 1'b0);
        tickClocks(1);
        checkOutput("rst_term_idle", 32'(CurrentValue), 32'h012);

        // Free-running stopwatch (target 0): single pulse at the 999 -> 000 wrap, edge 4000.
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
        tickClocks(1);
        Run = 1'b1;
        tickClocks(1);
        for (int i = 1; i < 4000; i++) begin
            tickClocks(1);
            if (DonePulse) pulseCount++;
        end
        checkOutput("free_pre_pulses", 32'(pulseCount), 32'h0);
        checkOutput("free_e3999_value", 32'(CurrentValue), 32'h999);
        tickClocks(1);
        checkOutput("free_wrap_value", 32'(CurrentValue), 32'h000);
        checkOutput("free_wrap_pulse", 32'(DonePulse), 32'h1);
        tickClocks(1);
        checkOutput("free_no_done", 32'(TimerDone), 32'h0);
        checkOutput("free_pulse_end", 32'(DonePulse), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
